// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong line-buffer sequencer.
package pingpong_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_t;

  localparam int NUM_BANKS = 2;

  function automatic logic bank_writable(input bank_state_t s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/pingpong_bank_fsm.sv
// Lifecycle of one buffer bank: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
module pingpong_bank_fsm
  import pingpong_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_fill_beat,
  input  logic        i_fill_last,
  input  logic        i_read_start,
  input  logic        i_release,
  output bank_state_t o_state
);

  bank_state_t r_state;
  bank_state_t w_state_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= BANK_EMPTY;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BANK_EMPTY: begin
        if (i_fill_last)      w_state_next = BANK_FULL;
        else if (i_fill_beat) w_state_next = BANK_FILLING;
      end
      BANK_FILLING: if (i_fill_last)  w_state_next = BANK_FULL;
      BANK_FULL:    if (i_read_start) w_state_next = BANK_READING;
      BANK_READING: if (i_release)    w_state_next = BANK_EMPTY;
      default:      w_state_next = BANK_EMPTY;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Two-bank ping-pong sequencer: column writes into one bank, 3x3 window reads from the other.
// Optional status ports (stall_cnt, bank_state) are enabled by defining PINGPONG_STATUS_EN.
module pingpong_buf_ctrl
  import pingpong_pkg::*;
#(
  parameter int COLUMNS     = 4,
  parameter int ROWS        = 3,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 write_enable_1,
  output logic                 write_enable_2,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic                 read_enable_1,
  output logic                 read_enable_2,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 rd_bank
`ifdef PINGPONG_STATUS_EN
  ,
  output logic [15:0]          stall_cnt,
  output logic [3:0]           bank_state
`endif
);

  localparam int NWIN = COLUMNS - KERNEL_SIZE + 1;
  localparam logic [ADDR_SIZE-1:0] LAST_COL = ADDR_SIZE'(COLUMNS - 1);
  localparam logic [ADDR_SIZE-1:0] NWIN_A   = ADDR_SIZE'(NWIN);
  localparam logic [ADDR_SIZE-1:0] LAST_WIN = ADDR_SIZE'(NWIN - 1);
  // A mis-parameterised instance never accepts data instead of producing bad windows.
  localparam logic CFG_OK = (ROWS == KERNEL_SIZE) && (COLUMNS >= KERNEL_SIZE);

  bank_state_t w_state [NUM_BANKS];

  logic                 r_wbank;
  logic                 r_rbank;
  logic [ADDR_SIZE-1:0] r_wcol;
  logic [ADDR_SIZE-1:0] r_wincol;
  logic [1:0]           r_read_en;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_rd_bank;
  logic                 r_win_valid;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_last_beat;
  logic                 w_issue;
  logic                 w_release;
  logic [NUM_BANKS-1:0] w_fill_beat;
  logic [NUM_BANKS-1:0] w_fill_last;
  logic [NUM_BANKS-1:0] w_read_start;
  logic [NUM_BANKS-1:0] w_bank_release;

  assign w_in_ready  = CFG_OK && !reset && bank_writable(w_state[r_wbank]);
  assign w_accept    = in_valid && w_in_ready;
  assign w_last_beat = w_accept && (r_wcol == LAST_COL);

  // rd_addr only moves on issue, so during a handshake it names the window being consumed.
  assign w_issue   = (w_state[r_rbank] == BANK_READING) && (r_wincol < NWIN_A) &&
                     !(|r_read_en) && (!r_win_valid || win_ready);
  assign w_release = r_win_valid && win_ready && (r_rd_addr == LAST_WIN);

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign w_fill_beat[gi]    = w_accept && (r_wbank == 1'(gi));
    assign w_fill_last[gi]    = w_last_beat && (r_wbank == 1'(gi));
    assign w_read_start[gi]   = (r_rbank == 1'(gi)) && (w_state[gi] == BANK_FULL);
    assign w_bank_release[gi] = w_release && (r_rbank == 1'(gi));

    pingpong_bank_fsm u_bank_fsm (
      .clk          (clk),
      .reset        (reset),
      .i_fill_beat  (w_fill_beat[gi]),
      .i_fill_last  (w_fill_last[gi]),
      .i_read_start (w_read_start[gi]),
      .i_release    (w_bank_release[gi]),
      .o_state      (w_state[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_wcol      <= '0;
      r_wincol    <= '0;
      r_read_en   <= 2'b00;
      r_rd_addr   <= '0;
      r_rd_bank   <= 1'b0;
      r_win_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wcol <= w_last_beat ? '0 : r_wcol + 1'b1;
        if (w_last_beat) r_wbank <= ~r_wbank;
      end
      r_read_en <= w_issue ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;
      if (w_issue) begin
        r_rd_addr <= r_wincol;
        r_rd_bank <= r_rbank;
        r_wincol  <= r_wincol + 1'b1;
      end
      if (w_release) begin
        r_rbank  <= ~r_rbank;
        r_wincol <= '0;
      end
      r_win_valid <= (|r_read_en) || (r_win_valid && !win_ready);
    end
  end

  assign in_ready       = w_in_ready;
  assign write_enable_1 = w_accept && !r_wbank;
  assign write_enable_2 = w_accept && r_wbank;
  assign wr_addr        = r_wcol;
  assign read_enable_1  = r_read_en[0];
  assign read_enable_2  = r_read_en[1];
  assign rd_addr        = r_rd_addr;
  assign rd_bank        = r_rd_bank;
  assign win_valid      = r_win_valid;

`ifdef PINGPONG_STATUS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (in_valid && !w_in_ready && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt  = r_stall_cnt;
  assign bank_state = {w_state[1], w_state[0]};
`endif

endmodule
